// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, flag bundle and flag-unit FSM states.
package alu_pkg;

  localparam int ALU_OPSEL_W = 3;

  typedef enum logic [ALU_OPSEL_W-1:0] {
    OP_ADD  = 3'b000,
    OP_PASS = 3'b001,
    OP_SUB  = 3'b010,
    OP_NOT  = 3'b011,
    OP_ADC  = 3'b100,
    OP_INC  = 3'b101,
    OP_SBC  = 3'b110,
    OP_CMP  = 3'b111
  } opsel_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    SINGLE = 1'b0,
    CHAIN  = 1'b1
  } flag_state_t;

endpackage

// File: rtl/alu_carry_sel.sv
// Combinational carry selection shared by every consumer of ALU carry-out.
module alu_carry_sel
  import alu_pkg::*;
(
  input  logic [ALU_OPSEL_W-1:0] opsel,
  input  logic                   mode,
  input  logic                   cout,
  output logic                   carry
);

  // Odd opcodes other than CMP produce no meaningful carry, so it is masked.
  always_comb begin
    carry = 1'b0;
    if (!mode) begin
      unique case (opsel_t'(opsel))
        OP_PASS, OP_NOT, OP_INC: carry = 1'b0;
        default:                 carry = cout;
      endcase
    end
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Registered C/Z/N/V flag unit with multi-word chaining and a save/restore shadow.
// Define ALU_FLAG_OVERFLOW_EN to build the overflow flag; otherwise v_flag is tied to 0.
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [ALU_OPSEL_W-1:0] opsel,
  input  logic                   mode,
  input  logic [WIDTH-1:0]       result,
  input  logic                   cout,
  input  logic                   a_msb,
  input  logic                   b_msb,
  input  logic                   chain,
  input  logic                   flag_we,
  input  logic                   save,
  input  logic                   restore,
  output logic                   c_flag,
  output logic                   z_flag,
  output logic                   n_flag,
  output logic                   v_flag,
  output logic                   carry_in,
  output logic                   valid_out,
  output logic                   in_chain
);

  logic        upd;
  logic        zr;
  logic        sel_carry;
  logic        v_next;
  logic        valid_q;
  alu_flags_t  flags_q;
  alu_flags_t  shadow_q;
  alu_flags_t  flags_new;
  flag_state_t state_q;
  flag_state_t state_d;

  alu_carry_sel u_carry_sel (
    .opsel (opsel),
    .mode  (mode),
    .cout  (cout),
    .carry (sel_carry)
  );

  assign upd = valid_in & flag_we & ~restore;
  assign zr  = ~|result;

`ifdef ALU_FLAG_OVERFLOW_EN
  assign v_next = ~mode & (a_msb == b_msb) & (result[WIDTH-1] != a_msb);
`else
  logic unused_msbs;
  assign unused_msbs = a_msb ^ b_msb;
  assign v_next      = 1'b0;
`endif

  // Inside a chain the zero flag accumulates, so only an all-zero multi-word value reads as zero.
  always_comb begin
    flags_new   = '0;
    flags_new.c = sel_carry;
    flags_new.z = (state_q == CHAIN) ? (zr & flags_q.z) : zr;
    flags_new.n = result[WIDTH-1];
    flags_new.v = v_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SINGLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restore)  state_d = SINGLE;
    else if (upd) state_d = chain ? CHAIN : SINGLE;
  end

  // Shadow always captures pre-edge flags, which makes save+restore a swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (restore)  flags_q <= shadow_q;
      else if (upd) flags_q <= flags_new;
      if (save)     shadow_q <= flags_q;
      valid_q <= upd;
    end
  end

  always_comb begin
    c_flag    = flags_q.c;
    z_flag    = flags_q.z;
    n_flag    = flags_q.n;
    v_flag    = flags_q.v;
    carry_in  = flags_q.c;
    valid_out = valid_q;
    in_chain  = (state_q == CHAIN);
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboard bench for alu_flag_unit: directed scenarios plus randomized traffic against a reference model.
module tb_alu_flag_unit;
  import alu_pkg::*;

  localparam int WIDTH = 8;
`ifdef ALU_FLAG_OVERFLOW_EN
  localparam bit V_EN = 1'b1;
`else
  localparam bit V_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [2:0]       opsel = '0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] result = '0;
  logic             cout = 1'b0;
  logic             a_msb = 1'b0;
  logic             b_msb = 1'b0;
  logic             chain = 1'b0;
  logic             flag_we = 1'b0;
  logic             save = 1'b0;
  logic             restore = 1'b0;
  logic             c_flag, z_flag, n_flag, v_flag, carry_in, valid_out, in_chain;

  always #5 clk = ~clk;

  alu_flag_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .opsel     (opsel),
    .mode      (mode),
    .result    (result),
    .cout      (cout),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .chain     (chain),
    .flag_we   (flag_we),
    .save      (save),
    .restore   (restore),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .n_flag    (n_flag),
    .v_flag    (v_flag),
    .carry_in  (carry_in),
    .valid_out (valid_out),
    .in_chain  (in_chain)
  );

  int checks = 0;
  int passed = 0;
  logic [6:0] exp_q[$];

  // Reference state: live flags, shadow copy, chaining status and last update indication.
  bit m_c, m_z, m_n, m_v, m_chain, m_vout;
  bit s_c, s_z, s_n, s_v;

  function automatic logic [6:0] snapshot();
    return {m_c, m_z, m_n, m_v, m_c, m_vout, m_chain};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {c_flag, z_flag, n_flag, v_flag, carry_in, valid_out, in_chain};
  endfunction

  task automatic check_output(input string name, input logic [6:0] actual, input logic [6:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
  endtask

  task automatic model_step(input bit rst, input bit v_in, input bit we, input bit [2:0] op,
                            input bit md, input bit [WIDTH-1:0] res, input bit co, input bit am,
                            input bit bm, input bit ch, input bit sv, input bit rs);
    bit upd, nc, nz, nn, nv;
    bit oc, oz, on, ov;
    if (!rst) begin
      {m_c, m_z, m_n, m_v, m_chain, m_vout} = '0;
      {s_c, s_z, s_n, s_v} = '0;
      return;
    end
    upd = v_in && we && !rs;
    nc  = !md && co && !(op == 3'd1 || op == 3'd3 || op == 3'd5);
    nz  = m_chain ? ((res == 0) && m_z) : (res == 0);
    nn  = res >= (1 << (WIDTH - 1));
    nv  = V_EN && !md && (am == bm) && (nn != am);
    {oc, oz, on, ov} = {m_c, m_z, m_n, m_v};
    if (rs) begin
      {m_c, m_z, m_n, m_v} = {s_c, s_z, s_n, s_v};
      m_chain = 1'b0;
    end else if (upd) begin
      {m_c, m_z, m_n, m_v} = {nc, nz, nn, nv};
      m_chain = ch;
    end
    if (sv) {s_c, s_z, s_n, s_v} = {oc, oz, on, ov};
    m_vout = upd;
  endtask

  task automatic apply_stimulus(input bit v_in, input bit we, input bit [2:0] op, input bit md,
                                input bit [WIDTH-1:0] res, input bit co, input bit am, input bit bm,
                                input bit ch, input bit sv, input bit rs);
    @(negedge clk);
    rst_n = 1'b1;
    valid_in = v_in; flag_we = we; opsel = op; mode = md; result = res; cout = co;
    a_msb = am; b_msb = bm; chain = ch; save = sv; restore = rs;
    model_step(1'b1, v_in, we, op, md, res, co, am, bm, ch, sv, rs);
    exp_q.push_back(snapshot());
  endtask

  task automatic hold_reset(input bit check_now);
    @(negedge clk);
    rst_n = 1'b0;
    valid_in = 1'b1; flag_we = 1'b1; opsel = '0; mode = 1'b0; result = '0; cout = 1'b1;
    a_msb = 1'b0; b_msb = 1'b0; chain = 1'b1; save = 1'b0; restore = 1'b0;
    model_step(1'b0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(snapshot());
    if (check_now) begin
      #1;
      check_output("async_reset", dut_vec(), 7'b0);
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic word(input bit [WIDTH-1:0] res, input bit co, input bit ch);
    apply_stimulus(1, 1, 3'd0, 0, res, co, 0, 0, ch, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a state, compare it with the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_output("scoreboard", dut_vec(), exp_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) hold_reset(1'b0);
    peek();
    check_output("reset_state", dut_vec(), 7'b0);

    word(8'h00, 1, 0);
    peek();
    check_output("add_zero", {3'b0, c_flag, z_flag, n_flag, valid_out}, 7'b0001101);

    for (int op = 0; op < 8; op++) begin
      apply_stimulus(1, 1, 3'(op), 0, 8'h10, 1, 0, 0, 0, 0, 0);
      peek();
      check_output($sformatf("carry_arith_op%0d", op), {6'b0, c_flag},
                   {6'b0, !(op == 1 || op == 3 || op == 5)});
    end
    for (int op = 0; op < 8; op++) begin
      apply_stimulus(1, 1, 3'(op), 1, 8'h10, 1, 0, 0, 0, 0, 0);
      peek();
      check_output($sformatf("carry_logic_op%0d", op), {6'b0, c_flag}, 7'b0);
    end

    apply_stimulus(1, 1, 3'd0, 0, 8'h80, 0, 0, 0, 0, 0, 0);
    peek();
    check_output("overflow", {5'b0, n_flag, v_flag}, {5'b0, 1'b1, V_EN});

    word(8'h00, 0, 1); peek(); check_output("chain_w1", {5'b0, z_flag, in_chain}, 7'b11);
    word(8'h01, 0, 1); peek(); check_output("chain_w2", {5'b0, z_flag, in_chain}, 7'b01);
    word(8'h00, 0, 0); peek(); check_output("chain_w3", {5'b0, z_flag, in_chain}, 7'b00);
    word(8'h00, 0, 1); peek(); check_output("zchain_w1", {5'b0, z_flag, in_chain}, 7'b11);
    word(8'h00, 0, 1); peek(); check_output("zchain_w2", {5'b0, z_flag, in_chain}, 7'b11);
    word(8'h00, 0, 0); peek(); check_output("zchain_w3", {5'b0, z_flag, in_chain}, 7'b10);

    word(8'h01, 1, 0);
    apply_stimulus(0, 1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    peek(); check_output("save", {4'b0, c_flag, z_flag, valid_out}, 7'b100);
    word(8'h00, 0, 0);
    peek(); check_output("post_save_upd", {5'b0, c_flag, z_flag}, 7'b01);
    apply_stimulus(1, 1, 3'd0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    peek(); check_output("restore", {4'b0, c_flag, z_flag, valid_out}, 7'b100);
    word(8'h00, 0, 0);
    apply_stimulus(0, 1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 1, 1);
    peek(); check_output("swap_flags", {5'b0, c_flag, z_flag}, 7'b10);
    apply_stimulus(0, 1, 3'd0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    peek(); check_output("swap_shadow", {5'b0, c_flag, z_flag}, 7'b01);

    word(8'h00, 1, 1);
    peek(); check_output("pre_reset_chain", {6'b0, in_chain}, 7'b1);
    hold_reset(1'b1);
    word(8'h00, 0, 1);
    peek(); check_output("post_reset_word", {5'b0, z_flag, in_chain}, 7'b11);
    word(8'h05, 0, 0);

    for (int i = 0; i < 400; i++) begin
      bit [WIDTH-1:0] res;
      res = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                     $urandom_range(0, 3) == 0, res, 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
